demux_1_to_2_16_bit_buffered: RTL and testbench
===============================================

DEMUX_1_TO_2_16_BIT_BUFFERED -- requirements
Module: demux_1_to_2_16_bit_buffered

Interface
REQ-001 Parameter WIDTH, default 16, data width of D, Y0 and Y1.
REQ-002 Parameter DEPTH, default 2, entries per output buffer; only 2 supported.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 CLK  input  1  clock; all state updates on the rising edge.
REQ-005 RST  input  1  synchronous active-high reset.
REQ-006 S  input  1  destination select: 0 routes to Y0, 1 routes to Y1.
REQ-007 D  input  16  write data.
REQ-008 D_VALID  input  1  D and S are valid this cycle.
REQ-009 D_READY  output  1  the selected buffer can accept D this cycle.
REQ-010 Y0  output  16  head entry of buffer 0.
REQ-011 Y0_VALID  output  1  buffer 0 is non-empty.
REQ-012 Y0_READY  input  1  consumer 0 takes the head entry.
REQ-013 Y1, Y1_VALID, Y1_READY: same as Y0, Y0_VALID and Y0_READY, for buffer 1.

Function
REQ-014 Push SHALL occur when D_VALID=1 and D_READY=1; D is written only into the buffer selected by S.
REQ-015 D_READY SHALL be combinational: D_READY = ~full0 when S=0, and D_READY = ~full1 when S=1. D_READY is independent of D_VALID and of Y0_READY/Y1_READY.
REQ-016 Each buffer SHALL have three states: EMPTY (count 0), ONE (count 1) and FULL (count 2).
  - EMPTY -> ONE on push.
  - ONE -> FULL on push without pop.
  - ONE -> EMPTY on pop without push.
  - ONE -> ONE on simultaneous push and pop.
  - FULL -> ONE on pop; push is impossible while FULL.
REQ-017 Pop SHALL occur when Yn_VALID=1 and Yn_READY=1; Yn_READY while EMPTY is ignored.
REQ-018 Latency SHALL be one cycle: data pushed at edge k appears on Yn with Yn_VALID=1 after edge k; there is no same-cycle bypass from D to Yn.
REQ-019 Yn SHALL be driven from a register; Yn = 16'h0000 whenever its buffer is EMPTY.
REQ-020 Each buffer SHALL preserve first-in, first-out order; its read and write pointers wrap modulo 2.
REQ-021 Traffic to one output SHALL never stall or alter the other output; both buffers may pop in the same cycle as a push to either buffer.
REQ-022 A full non-selected buffer SHALL NOT deassert D_READY.
REQ-023 S or D changing while D_VALID=0 SHALL have no effect on state.
REQ-024 Data width SHALL be exact: no truncation, extension or sign handling.

Reset
REQ-025 While RST=1 at a rising edge, both buffers SHALL go to EMPTY and all pointers to 0.
REQ-026 After that edge: Y0=Y1=16'h0000, Y0_VALID=Y1_VALID=0, and D_READY=1 for either S.
REQ-027 A push or pop coincident with RST=1 SHALL be discarded, including reset in the middle of a burst.
REQ-028 Storage contents need not be cleared; only the state and pointers are reset.

Structure
REQ-029 The constants WIDTH=16, DEPTH=2 and the state encodings EMPTY=2'b00, ONE=2'b01, FULL=2'b10 SHALL live in a shared include file used by all datapath blocks.
REQ-030 One sub-module, fifo_2_entry_16_bit (push, pop, din, dout, empty, full), SHALL be instantiated twice; the top level holds only select decode and the ready/valid logic.
REQ-031 No latches; no logic on the clock path.

Verification
REQ-032 Reset, then push S=0 D=16'h0034 -> next cycle Y0=16'h0034, Y0_VALID=1, Y1_VALID=0, Y1=16'h0000.
REQ-033 With Y1_READY=0, push S=1 with 16'h0012 then 16'h0056 -> third cycle D_READY=0 for S=1 and D_READY=1 for S=0; after popping, Y1 shows 16'h0012 then 16'h0056.
REQ-034 Buffer 0 in ONE holding 16'h0078, simultaneous push 16'h00BC with Y0_READY=1 -> state stays ONE, next Y0=16'h00BC, no loss or duplicate.
REQ-035 Buffer 0 FULL, D_VALID=1 S=0 D=16'h00F0 for 3 cycles with Y0_READY=0 -> no push, Y0 unchanged; meanwhile push S=1 D=16'h00DE -> accepted, Y1=16'h00DE.
REQ-036 RST=1 during an alternating S=0/S=1 burst (16'h009A, 16'h00BC) -> both outputs invalid and 16'h0000 next cycle; the coincident push is lost.
REQ-037 Random S, D_VALID and READY for 10,000 cycles -> scoreboard per output confirms order and count, with no drops or duplicates.

Source files
------------

// File: rtl/demux_1_to_2_16_bit_buffered_pkg.sv
// rtl/demux_1_to_2_16_bit_buffered_pkg.sv - shared constants and buffer state encoding
package demux_1_to_2_16_bit_buffered_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int BUF_DEPTH  = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } buf_state_e;

endpackage

// File: rtl/demux_1_to_2_16_bit_buffered_fifo.sv
// rtl/demux_1_to_2_16_bit_buffered_fifo.sv - two-entry FIFO with registered head output
module fifo_2_entry_16_bit
    import demux_1_to_2_16_bit_buffered_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH,
    parameter int DEPTH = BUF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    buf_state_e       state_q, state_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (state_q != FULL);
    assign do_pop  = pop && (state_q != EMPTY);
    assign empty   = (state_q == EMPTY);
    assign full    = (state_q == FULL);
    assign dout    = dout_q;

    // dout_d tracks the head the buffer will hold after this edge, so dout stays a pure register
    always_comb begin
        state_d  = state_q;
        dout_d   = dout_q;
        wr_ptr_d = wr_ptr_q ^ do_push;
        rd_ptr_d = rd_ptr_q ^ do_pop;
        case (state_q)
            EMPTY: begin
                if (do_push) begin
                    state_d = ONE;
                    dout_d  = din;
                end
            end
            ONE: begin
                if (do_push && !do_pop) begin
                    state_d = FULL;
                end else if (do_pop && !do_push) begin
                    state_d = EMPTY;
                    dout_d  = '0;
                end else if (do_push && do_pop) begin
                    dout_d  = din;
                end
            end
            FULL: begin
                if (do_pop) begin
                    state_d = ONE;
                    dout_d  = mem_q[~rd_ptr_q];
                end
            end
            default: begin
                state_d = EMPTY;
                dout_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            dout_q   <= dout_d;
        end
    end

    // Storage is deliberately left out of reset; state and pointers alone define contents
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/demux_1_to_2_16_bit_buffered.sv
// rtl/demux_1_to_2_16_bit_buffered.sv - 1-to-2 demux feeding two independent 2-entry buffers
module demux_1_to_2_16_bit_buffered
    import demux_1_to_2_16_bit_buffered_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH,
    parameter int DEPTH = BUF_DEPTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             S,
    input  logic [WIDTH-1:0] D,
    input  logic             D_VALID,
    output logic             D_READY,
    output logic [WIDTH-1:0] Y0,
    output logic             Y0_VALID,
    input  logic             Y0_READY,
    output logic [WIDTH-1:0] Y1,
    output logic             Y1_VALID,
    input  logic             Y1_READY
);

    logic empty0, full0, empty1, full1;
    logic push0, push1, pop0, pop1;

    // Ready reflects only the selected buffer so a full idle side never blocks the other
    assign D_READY  = S ? !full1 : !full0;
    assign push0    = D_VALID && D_READY && !S;
    assign push1    = D_VALID && D_READY && S;
    assign Y0_VALID = !empty0;
    assign Y1_VALID = !empty1;
    assign pop0     = Y0_VALID && Y0_READY;
    assign pop1     = Y1_VALID && Y1_READY;

    fifo_2_entry_16_bit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_buf0 (
        .clk   (CLK),
        .rst   (RST),
        .push  (push0),
        .pop   (pop0),
        .din   (D),
        .dout  (Y0),
        .empty (empty0),
        .full  (full0)
    );

    fifo_2_entry_16_bit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_buf1 (
        .clk   (CLK),
        .rst   (RST),
        .push  (push1),
        .pop   (pop1),
        .din   (D),
        .dout  (Y1),
        .empty (empty1),
        .full  (full1)
    );

endmodule

// File: tb/tb_demux_1_to_2_16_bit_buffered.sv
// tb/tb_demux_1_to_2_16_bit_buffered.sv - directed vectors plus randomized queue-model checking
module tb_demux_1_to_2_16_bit_buffered;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        S = 1'b0;
    logic [15:0] D = '0;
    logic        D_VALID = 1'b0;
    logic        D_READY;
    logic [15:0] Y0;
    logic        Y0_VALID;
    logic        Y0_READY = 1'b0;
    logic [15:0] Y1;
    logic        Y1_VALID;
    logic        Y1_READY = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    demux_1_to_2_16_bit_buffered dut (
        .CLK      (CLK),
        .RST      (RST),
        .S        (S),
        .D        (D),
        .D_VALID  (D_VALID),
        .D_READY  (D_READY),
        .Y0       (Y0),
        .Y0_VALID (Y0_VALID),
        .Y0_READY (Y0_READY),
        .Y1       (Y1),
        .Y1_VALID (Y1_VALID),
        .Y1_READY (Y1_READY)
    );

    typedef struct {
        logic        rst;
        logic        s;
        logic [15:0] d;
        logic        dv;
        logic        r0;
        logic        r1;
        logic        chk;
        logic        rdy;
        logic        y0v;
        logic [15:0] y0;
        logic        y1v;
        logic [15:0] y1;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic s, input logic [15:0] d, input logic dv,
                       input logic r0, input logic r1, input logic chk, input logic rdy,
                       input logic y0v, input logic [15:0] y0, input logic y1v, input logic [15:0] y1);
        vec_t v;
        v.rst = rst; v.s = s; v.d = d; v.dv = dv; v.r0 = r0; v.r1 = r1;
        v.chk = chk; v.rdy = rdy; v.y0v = y0v; v.y0 = y0; v.y1v = y1v; v.y1 = y1;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic s, input logic [15:0] d, input logic dv,
                         input logic r0, input logic r1);
        RST = rst; S = s; D = d; D_VALID = dv; Y0_READY = r0; Y1_READY = r1;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    logic [15:0] q0[$];
    logic [15:0] q1[$];

    initial begin
        // rst s d dv r0 r1 | chk rdy y0v y0 y1v y1
        add(1, 0, 16'h0000, 0, 0, 0, 0, 1, 0, 16'h0000, 0, 16'h0000);
        add(0, 0, 16'h0000, 0, 0, 0, 1, 1, 0, 16'h0000, 0, 16'h0000);
        add(0, 1, 16'h0000, 0, 0, 0, 1, 1, 0, 16'h0000, 0, 16'h0000);
        add(0, 0, 16'h0034, 1, 0, 0, 1, 1, 0, 16'h0000, 0, 16'h0000);
        add(0, 0, 16'h0000, 0, 0, 0, 1, 1, 1, 16'h0034, 0, 16'h0000);
        add(0, 0, 16'h0000, 0, 1, 0, 1, 1, 1, 16'h0034, 0, 16'h0000);
        add(0, 1, 16'h0012, 1, 0, 0, 1, 1, 0, 16'h0000, 0, 16'h0000);
        add(0, 1, 16'h0056, 1, 0, 0, 1, 1, 0, 16'h0000, 1, 16'h0012);
        add(0, 1, 16'h0099, 1, 0, 0, 1, 0, 0, 16'h0000, 1, 16'h0012);
        add(0, 0, 16'h0000, 0, 0, 0, 1, 1, 0, 16'h0000, 1, 16'h0012);
        add(0, 1, 16'h0000, 0, 0, 1, 1, 0, 0, 16'h0000, 1, 16'h0012);
        add(0, 1, 16'h0000, 0, 0, 1, 1, 1, 0, 16'h0000, 1, 16'h0056);
        add(0, 0, 16'h0000, 0, 0, 0, 1, 1, 0, 16'h0000, 0, 16'h0000);
        add(0, 0, 16'h0078, 1, 0, 0, 1, 1, 0, 16'h0000, 0, 16'h0000);
        add(0, 0, 16'h00BC, 1, 1, 0, 1, 1, 1, 16'h0078, 0, 16'h0000);
        add(0, 0, 16'h0000, 0, 0, 0, 1, 1, 1, 16'h00BC, 0, 16'h0000);
        add(0, 0, 16'h0011, 1, 0, 0, 1, 1, 1, 16'h00BC, 0, 16'h0000);
        for (int i = 0; i < 3; i++)
            add(0, 0, 16'h00F0, 1, 0, 0, 1, 0, 1, 16'h00BC, 0, 16'h0000);
        add(0, 1, 16'h00DE, 1, 0, 0, 1, 1, 1, 16'h00BC, 0, 16'h0000);
        add(0, 0, 16'h0000, 0, 0, 0, 1, 0, 1, 16'h00BC, 1, 16'h00DE);
        add(0, 1, 16'h0000, 0, 1, 1, 1, 1, 1, 16'h00BC, 1, 16'h00DE);
        add(0, 0, 16'h0000, 0, 1, 0, 1, 1, 1, 16'h0011, 0, 16'h0000);
        add(0, 0, 16'h0000, 0, 0, 0, 1, 1, 0, 16'h0000, 0, 16'h0000);
        add(0, 0, 16'h009A, 1, 0, 0, 1, 1, 0, 16'h0000, 0, 16'h0000);
        add(0, 1, 16'h00BC, 1, 0, 0, 1, 1, 1, 16'h009A, 0, 16'h0000);
        add(1, 0, 16'h009A, 1, 0, 0, 1, 1, 1, 16'h009A, 1, 16'h00BC);
        add(0, 1, 16'h0000, 0, 0, 0, 1, 1, 0, 16'h0000, 0, 16'h0000);
        add(0, 0, 16'h0000, 0, 1, 1, 1, 1, 0, 16'h0000, 0, 16'h0000);

        tick();
        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].s, vq[i].d, vq[i].dv, vq[i].r0, vq[i].r1);
            if (vq[i].chk) begin
                chk("dir_d_ready",  i, {31'b0, D_READY},  {31'b0, vq[i].rdy});
                chk("dir_y0_valid", i, {31'b0, Y0_VALID}, {31'b0, vq[i].y0v});
                chk("dir_y0",       i, {16'b0, Y0},       {16'b0, vq[i].y0});
                chk("dir_y1_valid", i, {31'b0, Y1_VALID}, {31'b0, vq[i].y1v});
                chk("dir_y1",       i, {16'b0, Y1},       {16'b0, vq[i].y1});
            end
            tick();
        end

        drive(1, 0, 16'h0000, 0, 0, 0);
        tick();
        q0.delete();
        q1.delete();

        for (int c = 0; c < 10000; c++) begin
            logic rst_r, s_r, dv_r, r0_r, r1_r, rdy_e, pop0, pop1;
            logic [15:0] d_r;
            rst_r = ($urandom_range(0, 499) == 0);
            s_r   = 1'($urandom_range(0, 1));
            dv_r  = ($urandom_range(0, 3) != 0);
            r0_r  = ($urandom_range(0, 2) != 0);
            r1_r  = ($urandom_range(0, 2) == 0);
            d_r   = 16'($urandom);
            drive(rst_r, s_r, d_r, dv_r, r0_r, r1_r);

            rdy_e = s_r ? (q1.size() < 2) : (q0.size() < 2);
            chk("rnd_d_ready",  c, {31'b0, D_READY},  {31'b0, rdy_e});
            chk("rnd_y0_valid", c, {31'b0, Y0_VALID}, {31'b0, (q0.size() > 0)});
            chk("rnd_y0",       c, {16'b0, Y0},       {16'b0, (q0.size() > 0) ? q0[0] : 16'h0000});
            chk("rnd_y1_valid", c, {31'b0, Y1_VALID}, {31'b0, (q1.size() > 0)});
            chk("rnd_y1",       c, {16'b0, Y1},       {16'b0, (q1.size() > 0) ? q1[0] : 16'h0000});

            if (rst_r) begin
                q0.delete();
                q1.delete();
            end else begin
                pop0 = r0_r && (q0.size() > 0);
                pop1 = r1_r && (q1.size() > 0);
                if (pop0) void'(q0.pop_front());
                if (pop1) void'(q1.pop_front());
                if (dv_r && rdy_e) begin
                    if (s_r) q1.push_back(d_r);
                    else     q0.push_back(d_r);
                end
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
